// File: rtl/tt_pkg.sv
// Shared types and default sizing for the truth-table capture block and its record FIFO.
package tt_pkg;

  localparam int unsigned TT_IN_W       = 13;
  localparam int unsigned TT_OUT_W      = 8;
  localparam int unsigned TT_SETTLE     = 2;
  localparam int unsigned TT_FIFO_DEPTH = 4;
  localparam int unsigned TT_REC_W      = TT_IN_W + TT_OUT_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } tt_state_e;

endpackage

// File: rtl/tt_fifo.sv
// Synchronous first-word-fall-through FIFO for {index, output} records.
// The head entry is visible on head_data whenever empty is low.
module tt_fifo #(
  parameter int unsigned WIDTH = tt_pkg::TT_REC_W,
  parameter int unsigned DEPTH = tt_pkg::TT_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A pop from a full FIFO frees the slot in time for a push in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tt_capture.sv
// Truth-table recorder: sweeps every input vector into a combinational DUT, captures the
// response after a settle time and streams {index, data} records over a valid/ready port.
module tt_capture
  import tt_pkg::*;
#(
  parameter int unsigned IN_W       = TT_IN_W,
  parameter int unsigned OUT_W      = TT_OUT_W,
  parameter int unsigned SETTLE     = TT_SETTLE,
  parameter int unsigned FIFO_DEPTH = TT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  i_x,
  input  logic [OUT_W-1:0] o_y,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [IN_W-1:0]  m_index,
  output logic [OUT_W-1:0] m_data,
  output logic             busy,
  output logic             done
);

  localparam int unsigned REC_W = IN_W + OUT_W;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW    = CW + 1;

  tt_state_e         state_q, state_d;
  logic [IN_W-1:0]   i_x_q, i_x_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REC_W-1:0]  rec_q, rec_d;
  logic              rec_vld_q, rec_vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [REC_W-1:0]  fifo_head;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]     fifo_count;
  logic [OW-1:0]     occ_next;
  logic              space_ok;

  tt_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rec_vld_q),
    .push_data (rec_q),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fifo_pop = !fifo_empty && m_ready;
  // The capture register is always flushed before the next CAPTURE (SETTLE >= 1), so only
  // the FIFO's own occupancy gates a capture.
  assign space_ok = !fifo_full || fifo_pop;
  assign occ_next = OW'(fifo_count) + OW'(rec_vld_q) - OW'(fifo_pop);

  always_comb begin
    state_d   = state_q;
    i_x_d     = i_x_q;
    cnt_d     = cnt_q;
    rec_d     = rec_q;
    rec_vld_d = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          i_x_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_APPLY: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (space_ok) begin
          rec_d     = {i_x_q, o_y};
          rec_vld_d = 1'b1;
          if (&i_x_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_APPLY;
            i_x_d   = i_x_q + IN_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Finish on the edge that accepts the final record, so busy drops exactly then.
        if (occ_next == '0) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      i_x_q     <= '0;
      cnt_q     <= '0;
      rec_q     <= '0;
      rec_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_x_q     <= i_x_d;
      cnt_q     <= cnt_d;
      rec_q     <= rec_d;
      rec_vld_q <= rec_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign i_x     = i_x_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign m_valid = !fifo_empty;
  assign {m_index, m_data} = fifo_empty ? '0 : fifo_head;

endmodule
